pe_mac_sequencer: RTL and testbench

PE_MAC_SEQUENCER -- requirements
Module: pe_mac_sequencer

---
 rtl/pe_seq_pkg.sv | 18 +
 rtl/pe_mac_sequencer_if.sv | 29 ++
 rtl/pe_seq_counter.sv | 34 +++
 rtl/pe_mac_sequencer.sv | 165 ++++++++++++++++
 tb/tb_pe_mac_sequencer.sv | 247 ++++++++++++++++++++++++
 5 files changed

// File: rtl/pe_seq_pkg.sv
// Shared definitions for the PE MAC sequencer: FSM state encoding and the
// default address/datapath widths used by every file in this block.
package pe_seq_pkg;

    // Default local-store address width.
    localparam int unsigned PE_SEQ_A = 7;
    // Default datapath width; only sizes the optional status counter.
    localparam int unsigned PE_SEQ_W = 16;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_LOAD    = 3'd1,
        ST_COMPUTE = 3'd2,
        ST_DRAIN   = 3'd3,
        ST_DONE    = 3'd4
    } state_t;

endpackage

// File: rtl/pe_mac_sequencer_if.sv
// Load/store/result bundle between the sequencer (master) and the PE
// datapath (slave): load-beat handshake, local-store addressing and write
// strobes, accumulator controls and the result handshake.
interface pe_mac_sequencer_if #(
    parameter int unsigned A = pe_seq_pkg::PE_SEQ_A
);
    logic         ld_valid;
    logic         ld_ready;
    logic [A-1:0] kernelAddress;
    logic [A-1:0] neuronAddress;
    logic         kernelWrite;
    logic         neuronWrite;
    logic         acc_clear;
    logic         mac_en;
    logic         res_valid;
    logic         res_ready;

    modport master (
        input  ld_valid, res_ready,
        output ld_ready, kernelAddress, neuronAddress, kernelWrite,
               neuronWrite, acc_clear, mac_en, res_valid
    );

    modport slave (
        output ld_valid, res_ready,
        input  ld_ready, kernelAddress, neuronAddress, kernelWrite,
               neuronWrite, acc_clear, mac_en, res_valid
    );
endinterface

// File: rtl/pe_seq_counter.sv
// Word counter shared by the LOAD and COMPUTE phases: synchronous clear has
// priority over enable, and o_tc flags the last word of the job (len-1).
module pe_seq_counter
    import pe_seq_pkg::*;
#(
    parameter int unsigned A = PE_SEQ_A
) (
    input  logic         CLK,
    input  logic         RST,
    input  logic         i_clr,
    input  logic         i_en,
    input  logic [A-1:0] i_len,
    output logic [A-1:0] o_count,
    output logic         o_tc
);
    localparam logic [A-1:0] ONE = A'(1);

    logic [A-1:0] r_count;

    // Count register: clear wins over enable so a phase change restarts at 0.
    always_ff @(posedge CLK or posedge RST) begin
        // NOTE: sequential state uses <= so every register samples pre-edge values.
        if (RST) begin
            r_count <= '0;
        end else if (i_clr) begin
            r_count <= '0;
        end else if (i_en) begin
            r_count <= r_count + ONE;
        end
    end

    assign o_count = r_count;
    assign o_tc    = (r_count == (i_len - ONE));
endmodule

// File: rtl/pe_mac_sequencer.sv
// PE MAC sequencer: accepts a job of len words, streams kernel/neuron load
// beats into the local store, replays the store addresses for the MAC pass,
// then presents a result handshake.
// Optional feature: define PE_SEQ_STATUS_EN to add the cycle_count status
// output (2*W bits, saturating job-duration counter).
module pe_mac_sequencer
    import pe_seq_pkg::*;
#(
    parameter int unsigned A = PE_SEQ_A,
    parameter int unsigned W = PE_SEQ_W
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              start,
    input  logic [A-1:0]      len,
    output logic              busy,
`ifdef PE_SEQ_STATUS_EN
    output logic [2*W-1:0]    cycle_count,
`endif
    pe_mac_sequencer_if.master bus
);

    // Widths of zero would collapse the address bus or the status counter.
    if (A < 1 || W < 1) begin : g_bad_params
        $error("pe_mac_sequencer: A and W must both be at least 1");
    end

    state_t       r_state;
    state_t       w_state_nxt;
    logic [A-1:0] r_len;
    logic         r_mac_en;

    logic         w_accept;
    logic         w_cnt_clr;
    logic         w_cnt_en;
    logic         w_cnt_tc;
    logic [A-1:0] w_cnt;
    logic         w_ld_ready;
    logic         w_write;
    logic         w_addr_phase;
    logic [A-1:0] w_addr;
    logic         w_res_valid;

    pe_seq_counter #(
        .A (A)
    ) u_counter (
        .CLK     (CLK),
        .RST     (RST),
        .i_clr   (w_cnt_clr),
        .i_en    (w_cnt_en),
        .i_len   (r_len),
        .o_count (w_cnt),
        .o_tc    (w_cnt_tc)
    );

    // Next-state and counter control; a zero-length start is dropped in IDLE.
    always_comb begin
        // NOTE: every output of this block gets a default first, so no latch is inferred.
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        w_cnt_clr   = 1'b0;
        w_cnt_en    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (start && (len != '0)) begin
                    w_accept    = 1'b1;
                    w_cnt_clr   = 1'b1;
                    w_state_nxt = ST_LOAD;
                end
            end
            ST_LOAD: begin
                if (bus.ld_valid) begin
                    if (w_cnt_tc) begin
                        w_cnt_clr   = 1'b1;
                        w_state_nxt = ST_COMPUTE;
                    end else begin
                        w_cnt_en = 1'b1;
                    end
                end
            end
            ST_COMPUTE: begin
                if (w_cnt_tc) begin
                    w_cnt_clr   = 1'b1;
                    w_state_nxt = ST_DRAIN;
                end else begin
                    w_cnt_en = 1'b1;
                end
            end
            ST_DRAIN: begin
                w_state_nxt = ST_DONE;
            end
            ST_DONE: begin
                if (bus.res_ready) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // FSM state register; reset returns to IDLE even mid-job.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Job length is captured only when a start is accepted.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_len <= '0;
        end else if (w_accept) begin
            r_len <= len;
        end
    end

    // mac_en trails COMPUTE by one cycle to line up with the store read data.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_mac_en <= 1'b0;
        end else begin
            r_mac_en <= (r_state == ST_COMPUTE);
        end
    end

    assign busy         = (r_state != ST_IDLE);
    assign w_ld_ready   = (r_state == ST_LOAD);
    assign w_write      = bus.ld_valid & w_ld_ready;
    assign w_addr_phase = (r_state == ST_LOAD) || (r_state == ST_COMPUTE);
    assign w_addr       = w_addr_phase ? w_cnt : '0;
    assign w_res_valid  = (r_state == ST_DONE);

    assign bus.ld_ready      = w_ld_ready;
    assign bus.kernelWrite   = w_write;
    assign bus.neuronWrite   = w_write;
    assign bus.kernelAddress = w_addr;
    assign bus.neuronAddress = w_addr;
    // The accept decode is combinational, so mask it while reset is held.
    assign bus.acc_clear     = w_accept & ~RST;
    assign bus.mac_en        = r_mac_en;
    assign bus.res_valid     = w_res_valid;

`ifdef PE_SEQ_STATUS_EN
    logic [2*W-1:0] r_cycle_count;

    // Job duration: the accepting IDLE cycle counts as 1, then every busy
    // cycle until res_valid; saturates and holds until the next accept.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_cycle_count <= '0;
        end else if (w_accept) begin
            r_cycle_count <= {{(2*W-1){1'b0}}, 1'b1};
        end else if (busy && !w_res_valid && (r_cycle_count != '1)) begin
            r_cycle_count <= r_cycle_count + 1'b1;
        end
    end

    assign cycle_count = r_cycle_count;
`endif

endmodule

// File: tb/tb_pe_mac_sequencer.sv
// Self-checking bench for pe_mac_sequencer: a table of complete jobs with
// hand-computed expectations, plus directed sequences for reset, ignored
// starts and reset in the middle of COMPUTE.
`timescale 1ns/1ps
module tb_pe_mac_sequencer;
    import pe_seq_pkg::*;

    localparam int unsigned A = 7;
    localparam int unsigned W = 16;

    typedef struct {
        logic [A-1:0] len;
        logic [31:0]  vpat;
        int           stall;
        int           exp_writes;
        int           exp_macs;
        int           exp_cc;
    } vec_t;

    logic         CLK;
    logic         RST;
    logic         start;
    logic [A-1:0] len;
    logic         busy;
`ifdef PE_SEQ_STATUS_EN
    logic [2*W-1:0] cycle_count;
`endif

    pe_mac_sequencer_if #(.A(A)) bus ();

    pe_mac_sequencer #(
        .A (A),
        .W (W)
    ) dut (
        .CLK         (CLK),
        .RST         (RST),
        .start       (start),
        .len         (len),
        .busy        (busy),
`ifdef PE_SEQ_STATUS_EN
        .cycle_count (cycle_count),
`endif
        .bus         (bus)
    );

    int n_tests = 0;
    int n_fail  = 0;

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d required %0d", name, act, exp);
        end
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_busy"},      32'(busy),              0);
        check({tag, "_ld_ready"},  32'(bus.ld_ready),      0);
        check({tag, "_kwrite"},    32'(bus.kernelWrite),   0);
        check({tag, "_nwrite"},    32'(bus.neuronWrite),   0);
        check({tag, "_kaddr"},     32'(bus.kernelAddress), 0);
        check({tag, "_naddr"},     32'(bus.neuronAddress), 0);
        check({tag, "_acc_clear"}, 32'(bus.acc_clear),     0);
        check({tag, "_mac_en"},    32'(bus.mac_en),        0);
        check({tag, "_res_valid"}, 32'(bus.res_valid),     0);
    endtask

    // One complete job driven from IDLE; the bench tracks the phase itself
    // from the load pattern and compares every cycle against it.
    task automatic run_job(input vec_t v, input string tag);
        int beats;
        int k;
        int writes;
        int macs;
        int l;
        int done_j;
        l      = int'(v.len);
        done_j = l + 1 + v.stall;
        beats  = 0;
        k      = 0;
        writes = 0;
        macs   = 0;

        @(posedge CLK); #1;
        start = 1'b1; len = v.len; bus.ld_valid = 1'b0; bus.res_ready = 1'b0;
        #1;
        check({tag, "_accept_acc_clear"}, 32'(bus.acc_clear), 1);
        check({tag, "_accept_busy"},      32'(busy),          0);
        @(posedge CLK); #1;
        start = 1'b0;

        while (beats < l) begin
            if (k >= 1000) begin
                check({tag, "_load_budget"}, 32'(beats), 32'(l));
                break;
            end
            bus.ld_valid = v.vpat[k % 32];
            #1;
            check({tag, "_load_ready"}, 32'(bus.ld_ready),      1);
            check({tag, "_load_busy"},  32'(busy),              1);
            check({tag, "_load_kaddr"}, 32'(bus.kernelAddress), 32'(beats));
            check({tag, "_load_naddr"}, 32'(bus.neuronAddress), 32'(beats));
            check({tag, "_load_kwr"},   32'(bus.kernelWrite),   32'(bus.ld_valid));
            check({tag, "_load_nwr"},   32'(bus.neuronWrite),   32'(bus.ld_valid));
            if (bus.kernelWrite === 1'b1) writes++;
            if (bus.ld_valid) beats++;
            k++;
            @(posedge CLK); #1;
        end
        bus.ld_valid = 1'b0;

        for (int j = 0; j <= done_j; j++) begin
            bus.res_ready = (j >= done_j);
            #1;
            check({tag, "_run_kaddr"},  32'(bus.kernelAddress), (j < l) ? 32'(j) : 0);
            check({tag, "_run_naddr"},  32'(bus.neuronAddress), (j < l) ? 32'(j) : 0);
            check({tag, "_run_ready"},  32'(bus.ld_ready),      0);
            check({tag, "_run_kwr"},    32'(bus.kernelWrite),   0);
            check({tag, "_run_mac_en"}, 32'(bus.mac_en),        (j >= 1 && j <= l) ? 1 : 0);
            check({tag, "_run_res_vl"}, 32'(bus.res_valid),     (j >= l + 1) ? 1 : 0);
            check({tag, "_run_busy"},   32'(busy),              1);
            if (bus.mac_en === 1'b1) macs++;
            @(posedge CLK); #1;
        end
        bus.res_ready = 1'b0;
        #1;
        check({tag, "_end_busy"},   32'(busy),          0);
        check({tag, "_end_res_vl"}, 32'(bus.res_valid), 0);
        check({tag, "_writes"},     32'(writes),        32'(v.exp_writes));
        check({tag, "_macs"},       32'(macs),          32'(v.exp_macs));
`ifdef PE_SEQ_STATUS_EN
        check({tag, "_cycle_count"}, cycle_count, 32'(v.exp_cc));
        @(posedge CLK); #1;
        check({tag, "_cycle_hold"},  cycle_count, 32'(v.exp_cc));
`endif
    endtask

    vec_t vecs [5];

    initial begin
        vecs[0] = '{len: 7'd4,   vpat: 32'hFFFF_FFFF, stall: 0, exp_writes: 4,   exp_macs: 4,   exp_cc: 10};
        vecs[1] = '{len: 7'd3,   vpat: 32'h0000_0015, stall: 0, exp_writes: 3,   exp_macs: 3,   exp_cc: 10};
        vecs[2] = '{len: 7'd1,   vpat: 32'hFFFF_FFFF, stall: 2, exp_writes: 1,   exp_macs: 1,   exp_cc: 4};
        vecs[3] = '{len: 7'd127, vpat: 32'hFFFF_FFFF, stall: 0, exp_writes: 127, exp_macs: 127, exp_cc: 256};
        vecs[4] = '{len: 7'd2,   vpat: 32'h0000_0006, stall: 5, exp_writes: 2,   exp_macs: 2,   exp_cc: 7};

        // Reset with a valid-looking start and load beat applied.
        RST = 1'b1; start = 1'b1; len = 7'd5; bus.ld_valid = 1'b1; bus.res_ready = 1'b0;
        #1;
        check_zero("reset");
        @(posedge CLK); #1;
        @(posedge CLK); #1;
        check_zero("reset_held");
        RST = 1'b0; start = 1'b0; bus.ld_valid = 1'b0;

        // Zero-length start is dropped.
        @(posedge CLK); #1;
        start = 1'b1; len = '0;
        #1;
        check("len0_acc_clear", 32'(bus.acc_clear), 0);
        @(posedge CLK); #1;
        start = 1'b0;
        #1;
        check("len0_busy", 32'(busy), 0);

        // Table of complete jobs.
        for (int i = 0; i < 5; i++) begin
            run_job(vecs[i], $sformatf("job%0d", i));
        end

        // Start during a stalled LOAD is ignored and the counter holds.
        @(posedge CLK); #1;
        start = 1'b1; len = 7'd2; bus.ld_valid = 1'b0;
        #1;
        check("busy_start_accept", 32'(bus.acc_clear), 1);
        @(posedge CLK); #1;
        len = 7'd5;
        for (int i = 0; i < 3; i++) begin
            #1;
            check("busy_start_acc_clear", 32'(bus.acc_clear),     0);
            check("busy_start_busy",      32'(busy),              1);
            check("busy_start_ready",     32'(bus.ld_ready),      1);
            check("busy_start_addr",      32'(bus.kernelAddress), 0);
            check("busy_start_kwr",       32'(bus.kernelWrite),   0);
            @(posedge CLK); #1;
        end
        start = 1'b0; bus.ld_valid = 1'b1;
        for (int i = 0; i < 2; i++) begin
            #1;
            check("busy_start_beat_addr", 32'(bus.kernelAddress), 32'(i));
            check("busy_start_beat_kwr",  32'(bus.kernelWrite),   1);
            @(posedge CLK); #1;
        end
        bus.ld_valid = 1'b0;
        for (int j = 0; j < 4; j++) begin
            bus.res_ready = (j == 3);
            #1;
            check("busy_start_cmp_addr", 32'(bus.kernelAddress), (j < 2) ? 32'(j) : 0);
            check("busy_start_res_vl",   32'(bus.res_valid),     (j == 3) ? 1 : 0);
            @(posedge CLK); #1;
        end
        bus.res_ready = 1'b0;
        #1;
        check("busy_start_idle", 32'(busy), 0);

        // Reset at COMPUTE address 2 of a len=8 job.
        @(posedge CLK); #1;
        start = 1'b1; len = 7'd8;
        @(posedge CLK); #1;
        start = 1'b0; bus.ld_valid = 1'b1;
        repeat (8) @(posedge CLK);
        #1;
        bus.ld_valid = 1'b0;
        @(posedge CLK); #1;
        @(posedge CLK); #1;
        #1;
        check("midrst_pre_addr",   32'(bus.kernelAddress), 2);
        check("midrst_pre_mac_en", 32'(bus.mac_en),        1);
        RST = 1'b1;
        #1;
        check_zero("midrst");
        @(posedge CLK); #1;
        RST = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            check("midrst_post_mac_en", 32'(bus.mac_en), 0);
            check("midrst_post_busy",   32'(busy),       0);
            @(posedge CLK); #1;
        end
        run_job('{len: 7'd2, vpat: 32'hFFFF_FFFF, stall: 0, exp_writes: 2, exp_macs: 2, exp_cc: 6}, "postrst");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    // Watchdog so the bench can never hang.
    initial begin
        #500000;
        $display("FAIL watchdog: got timeout required completion");
        $fatal(1, "watchdog expired");
    end

endmodule
